// File: rtl/demosaic_frame_ctrl.sv
// Frame sequencer for the Bayer demosaic: clears the demosaic, streams one raw frame
// from the frame buffer in raster order, appends two zero rows, then waits for done.
module demosaic_frame_ctrl #(
  parameter int width   = 320,
  parameter int height  = 240,
  parameter int ADDR_W  = 17,
  parameter int TIMEOUT = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              iStart,
  input  logic              iStall,
  output logic              oRdEn,
  output logic [ADDR_W-1:0] oRdAddr,
  input  logic [7:0]        iRdData,
  output logic              oDemosaicReset,
  output logic [7:0]        oPixData,
  output logic              oPixValid,
  input  logic              iDemosaicDone,
  output logic              oBusy,
  output logic              oFrameDone,
  output logic [15:0]       oFrameCount,
  output logic              oError,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_FETCH, S_FLUSH, S_DRAIN, S_DONE
  } state_t;

  // One counter walks both the pixel addresses and the flush beats, so it must hold both ranges.
  localparam int FLUSH_W = $clog2(2 * width);
  localparam int CNT_W   = (ADDR_W > FLUSH_W) ? ADDR_W : FLUSH_W;
  localparam int TMR_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] LAST_PIX   = CNT_W'(width * height - 1);
  localparam logic [CNT_W-1:0] LAST_FLUSH = CNT_W'(2 * width - 1);
  localparam logic [TMR_W-1:0] LAST_WAIT  = TMR_W'(TIMEOUT - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic               valid_q, valid_d;
  logic               fetch_q, fetch_d;
  logic [15:0]        frame_cnt_q, frame_cnt_d;
  logic               err_q, err_d;
  logic               issue;

  // Beat protocol: a beat is issued in any FETCH/FLUSH cycle with iStall low; it appears
  // on oPixValid/oPixData exactly one cycle later, which is when iRdData for a FETCH
  // beat arrives. There is no ready: the demosaic accepts every valid beat.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    tmr_d       = tmr_q;
    err_d       = err_q;
    frame_cnt_d = frame_cnt_q;
    issue       = 1'b0;
    fetch_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (iStart) begin
          state_d = S_CLEAR;
          err_d   = 1'b0;
          cnt_d   = '0;
        end
      end
      S_CLEAR: state_d = S_FETCH;
      S_FETCH: begin
        if (!iStall) begin
          issue   = 1'b1;
          fetch_d = 1'b1;
          if (cnt_q == LAST_PIX) begin
            cnt_d   = '0;
            state_d = S_FLUSH;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_FLUSH: begin
        if (!iStall) begin
          issue = 1'b1;
          if (cnt_q == LAST_FLUSH) begin
            cnt_d   = '0;
            tmr_d   = '0;
            state_d = S_DRAIN;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_DRAIN: begin
        if (iDemosaicDone) begin
          state_d = S_DONE;
        end else if (tmr_q == LAST_WAIT) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      S_DONE: begin
        frame_cnt_d = frame_cnt_q + 16'd1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    valid_d = issue;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      tmr_q       <= '0;
      valid_q     <= 1'b0;
      fetch_q     <= 1'b0;
      frame_cnt_q <= 16'd0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tmr_q       <= tmr_d;
      valid_q     <= valid_d;
      fetch_q     <= fetch_d;
      frame_cnt_q <= frame_cnt_d;
      err_q       <= err_d;
    end
  end

  assign oRdEn          = (state_q == S_FETCH) && !iStall;
  assign oRdAddr        = oRdEn ? cnt_q[ADDR_W-1:0] : '0;
  assign oDemosaicReset = reset | (state_q == S_CLEAR);
  assign oPixValid      = valid_q;
  assign oPixData       = (valid_q && fetch_q) ? iRdData : 8'd0;
  assign oBusy          = (state_q != S_IDLE);
  assign oFrameDone     = (state_q == S_DONE);
  assign oFrameCount    = frame_cnt_q;
  assign oError         = err_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_demosaic_frame_ctrl.sv
// Bench for demosaic_frame_ctrl on a 4x2 frame: a timeline model predicts every output
// per cycle relative to the accepted start, with directed frames and literal anchors.
module tb_demosaic_frame_ctrl;

  localparam int W    = 4;
  localparam int H    = 2;
  localparam int AW   = 3;
  localparam int TO   = 8;
  localparam int NPIX = W * H;
  localparam int NB   = W * (H + 2);
  localparam int LEN  = 44;

  logic          clk = 1'b0;
  logic          reset, iStart, iStall, iDemosaicDone;
  logic          oRdEn, oDemosaicReset, oPixValid, oBusy, oFrameDone, oError;
  logic [AW-1:0] oRdAddr;
  logic [7:0]    iRdData = 8'h00;
  logic [7:0]    oPixData;
  logic [15:0]   oFrameCount;
  logic [2:0]    dbg_state;

  demosaic_frame_ctrl #(.width(W), .height(H), .ADDR_W(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .iStart(iStart), .iStall(iStall),
    .oRdEn(oRdEn), .oRdAddr(oRdAddr), .iRdData(iRdData),
    .oDemosaicReset(oDemosaicReset), .oPixData(oPixData), .oPixValid(oPixValid),
    .iDemosaicDone(iDemosaicDone), .oBusy(oBusy), .oFrameDone(oFrameDone),
    .oFrameCount(oFrameCount), .oError(oError), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // frame buffer: mem[a] = a+1, garbage when not read
  always @(posedge clk) iRdData <= oRdEn ? 8'(oRdAddr + 1) : 8'h5A;

  int total = 0;
  int bad   = 0;
  int rel   = 0;
  bit chk_en = 1'b0;

  int exp_rden[LEN], exp_addr[LEN], exp_valid[LEN], exp_data[LEN];
  int exp_busy[LEN], exp_fdone[LEN], exp_dreset[LEN], exp_err[LEN], exp_cnt[LEN];
  int exp_done_rel;
  int stall_mode = 0;
  bit dm_en = 1'b1;
  int model_cnt = 0;
  bit model_err = 1'b0;

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int fdone_seen, fdone_rel;
  int dm_beats = 0;
  bit dm_done_next = 1'b0;

  task automatic chk(input string nm, input int act, input int want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s rel=%0d got=%0d want=%0d", nm, rel, act, want);
    end
  endtask

  function automatic bit stall_at(input int r);
    return (stall_mode == 1) && (r >= 2) && (((r - 2) % 2) == 0);
  endfunction

  // timeline model: CLEAR at 1, beats from 2 skipping stalled cycles, data one cycle later,
  // DONE two cycles after draining starts (demosaic answers) or TIMEOUT cycles in
  task automatic build_exp();
    int c;
    for (int r = 0; r < LEN; r++) begin
      exp_rden[r] = 0; exp_addr[r] = 0; exp_valid[r] = 0; exp_data[r] = 0;
      exp_busy[r] = 0; exp_fdone[r] = 0; exp_dreset[r] = 0;
      exp_err[r] = model_err; exp_cnt[r] = model_cnt;
    end
    exp_dreset[1] = 1;
    c = 2;
    for (int k = 0; k < NB; k++) begin
      while (stall_at(c)) c++;
      if (k < NPIX) begin
        exp_rden[c]   = 1;
        exp_addr[c]   = k;
        exp_data[c+1] = (k + 1) % 256;
      end
      exp_valid[c+1] = 1;
      c++;
    end
    exp_done_rel = dm_en ? c + 2 : c + TO;
    for (int r = 1; r < LEN; r++) begin
      exp_busy[r] = (r <= exp_done_rel) ? 1 : 0;
      exp_err[r]  = (!dm_en && r >= exp_done_rel) ? 1 : 0;
      if (r > exp_done_rel) exp_cnt[r] = (model_cnt + 1) % 65536;
    end
    exp_fdone[exp_done_rel] = 1;
  endtask

  // scoreboard compare, every cycle of a modelled frame
  always @(negedge clk) begin
    if (chk_en && rel < LEN) begin
      chk("rd_en", int'(oRdEn), exp_rden[rel]);
      chk("rd_addr", int'(oRdAddr), exp_addr[rel]);
      chk("pix_valid", int'(oPixValid), exp_valid[rel]);
      chk("pix_data", int'(oPixData), exp_data[rel]);
      chk("busy", int'(oBusy), exp_busy[rel]);
      chk("frame_done", int'(oFrameDone), exp_fdone[rel]);
      chk("demosaic_reset", int'(oDemosaicReset), exp_dreset[rel]);
      chk("error", int'(oError), exp_err[rel]);
      chk("frame_count", int'(oFrameCount), exp_cnt[rel]);
      if (oPixValid) got_q.push_back(oPixData);
      if (oFrameDone) begin
        fdone_seen++;
        fdone_rel = rel;
      end
    end
  end

  // driver: demosaic model raises done the cycle after its last expected beat
  task automatic tick();
    @(negedge clk);
    if (oDemosaicReset) dm_beats = 0;
    else if (oPixValid) dm_beats++;
    dm_done_next = dm_en && !oDemosaicReset && oPixValid && (dm_beats == NB);
    @(posedge clk);
    #1;
    rel++;
    iStart        = 1'b0;
    iDemosaicDone = dm_done_next;
    iStall        = stall_at(rel);
  endtask

  task automatic run_frame(input int mode, input bit dmen, input int ign_start);
    stall_mode = mode;
    dm_en      = dmen;
    build_exp();
    got_q.delete();
    fdone_seen = 0;
    fdone_rel  = -1;
    rel        = 0;
    iStart     = 1'b1;
    iStall     = stall_at(0);
    chk_en     = 1'b1;
    repeat (LEN) begin
      tick();
      if (ign_start >= 0 && (rel == ign_start || rel == exp_done_rel)) iStart = 1'b1;
    end
    chk_en    = 1'b0;
    iStart    = 1'b0;
    model_cnt = (model_cnt + 1) % 65536;
    model_err = !dmen;
  endtask

  initial begin
    reset = 1'b1; iStart = 1'b0; iStall = 1'b0; iDemosaicDone = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_rd_en", int'(oRdEn), 0);
    chk("reset_rd_addr", int'(oRdAddr), 0);
    chk("reset_pix_valid", int'(oPixValid), 0);
    chk("reset_pix_data", int'(oPixData), 0);
    chk("reset_busy", int'(oBusy), 0);
    chk("reset_frame_done", int'(oFrameDone), 0);
    chk("reset_frame_count", int'(oFrameCount), 0);
    chk("reset_error", int'(oError), 0);
    chk("reset_demosaic_reset", int'(oDemosaicReset), 1);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // nominal frame
    run_frame(0, 1'b1, -1);
    chk("nominal_done_pulses", fdone_seen, 1);
    chk("nominal_done_cycle", fdone_rel, 20);
    chk("nominal_count", int'(oFrameCount), 1);
    chk("nominal_error", int'(oError), 0);

    // alternating stall
    run_frame(1, 1'b1, -1);
    chk("stall_done_cycle", fdone_rel, 36);
    exp_q.delete();
    for (int i = 1; i <= NPIX; i++) exp_q.push_back(8'(i));
    for (int i = 0; i < 2 * W; i++) exp_q.push_back(8'd0);
    chk("stall_beat_count", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk("stall_beat_data", int'(got_q[i]), int'(exp_q[i]));

    // starts during FETCH and DONE are ignored
    run_frame(0, 1'b1, 5);
    chk("ignored_done_pulses", fdone_seen, 1);
    chk("ignored_done_cycle", fdone_rel, 20);
    chk("ignored_count", int'(oFrameCount), 3);

    // drain timeout, error sticky until next start
    run_frame(0, 1'b0, -1);
    chk("timeout_done_cycle", fdone_rel, 26);
    chk("timeout_error_sticky", int'(oError), 1);
    run_frame(0, 1'b1, -1);
    chk("error_cleared", int'(oError), 0);
    chk("after_timeout_count", int'(oFrameCount), 5);

    // reset mid-frame
    stall_mode = 0;
    dm_en      = 1'b1;
    rel        = 0;
    iStart     = 1'b1;
    repeat (6) tick();
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_demosaic_reset", int'(oDemosaicReset), 1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    rel   = 7;
    @(negedge clk);
    chk("midrst_rd_en", int'(oRdEn), 0);
    chk("midrst_pix_valid", int'(oPixValid), 0);
    chk("midrst_pix_data", int'(oPixData), 0);
    chk("midrst_busy", int'(oBusy), 0);
    chk("midrst_demosaic_reset", int'(oDemosaicReset), 0);
    chk("midrst_count", int'(oFrameCount), 0);
    chk("midrst_error", int'(oError), 0);
    @(posedge clk);
    #1;
    dm_beats  = 0;
    model_cnt = 0;
    model_err = 1'b0;
    run_frame(0, 1'b1, -1);
    chk("post_reset_done_cycle", fdone_rel, 20);
    chk("post_reset_count", int'(oFrameCount), 1);

    // frame counter wrap
    @(negedge clk);
    force dut.frame_cnt_q = 16'hFFFF;
    @(posedge clk);
    @(negedge clk);
    release dut.frame_cnt_q;
    chk("wrap_preload", int'(oFrameCount), 65535);
    @(posedge clk);
    #1;
    model_cnt = 65535;
    run_frame(0, 1'b1, -1);
    chk("wrap_count", int'(oFrameCount), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
